// File: rtl/sid_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_seq_pkg                                                                |
// | Shared opcodes, FSM states and command layout for the SID write sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sid_seq_pkg;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_WAIT  = 1'b1;

    localparam int DEF_VOICE_W = 2;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_PAY_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAIT   = 3'd4
    } seq_state_t;

    // Command word layout for the default configuration, as seen by host shims.
    typedef struct packed {
        logic                   op;
        logic [DEF_VOICE_W-1:0] voice;
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_PAY_W-1:0]   payload;
    } sid_cmd_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_seq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_seq_fifo                                                               |
// | Synchronous show-ahead command FIFO with flush; head visible on rd_data.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sid_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_CW-1:0] C_FULL    = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
    localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full    = (r_count == C_FULL);
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // A pop frees the head slot, so a push is still accepted on a full FIFO.
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && !flush && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sid_write_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_write_sequencer                                                        |
// | Replays queued timed register writes and waits onto the SID write port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sid_write_sequencer
    import sid_seq_pkg::*;
#(
    parameter int VOICE_W    = 2,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int PAY_W      = 24,
    parameter int DEPTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [VOICE_W-1:0] cmd_voice,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [PAY_W-1:0]   cmd_payload,
    input  logic               run,
    input  logic               abort,
    output logic [VOICE_W-1:0] bus_voice,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic [DATA_W-1:0]  bus_data,
    output logic               bus_we,
    output logic               cmd_done,
    output logic               idle,
    output logic               overflow
);

    typedef struct packed {
        logic               op;
        logic [VOICE_W-1:0] voice;
        logic [ADDR_W-1:0]  addr;
        logic [PAY_W-1:0]   payload;
    } cmd_t;

    // One phase counter serves SETUP/STROBE/HOLD, sized for the longest phase.
    localparam int C_SETUP_W  = cnt_w(SETUP_CYC);
    localparam int C_STROBE_W = cnt_w(STROBE_CYC);
    localparam int C_HOLD_W   = cnt_w(HOLD_CYC);
    localparam int C_SS_W     = (C_SETUP_W > C_STROBE_W) ? C_SETUP_W : C_STROBE_W;
    localparam int C_PH_W     = (C_SS_W > C_HOLD_W) ? C_SS_W : C_HOLD_W;

    localparam logic [C_PH_W-1:0] C_SETUP_LD  = C_PH_W'(SETUP_CYC);
    localparam logic [C_PH_W-1:0] C_STROBE_LD = C_PH_W'(STROBE_CYC);
    localparam logic [C_PH_W-1:0] C_HOLD_LD   = C_PH_W'(HOLD_CYC);
    localparam logic [C_PH_W-1:0] C_PH_ONE    = C_PH_W'(1);
    localparam logic [PAY_W-1:0]  C_WAIT_ONE  = PAY_W'(1);

    cmd_t               w_cmd_in;
    cmd_t               w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    seq_state_t         r_state;
    logic [C_PH_W-1:0]  r_ph_cnt;
    logic [PAY_W-1:0]   r_wait_cnt;
    logic [VOICE_W-1:0] r_bus_voice;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_data;
    logic               r_bus_we;
    logic               r_done;
    logic               r_overflow;

    assign w_cmd_in  = {cmd_op, cmd_voice, cmd_addr, cmd_payload};
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full && !abort;
    assign w_pop     = (r_state == ST_IDLE) && run && !w_empty && !abort;

    sid_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (abort),
        .wr_data (w_cmd_in),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ph_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_bus_voice <= '0;
            r_bus_addr  <= '0;
            r_bus_data  <= '0;
            r_bus_we    <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (abort) begin
            // Bus address/data deliberately keep their last driven values.
            r_state    <= ST_IDLE;
            r_ph_cnt   <= '0;
            r_wait_cnt <= '0;
            r_bus_we   <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cmd_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_head.op == OP_WRITE) begin
                            r_bus_voice <= w_head.voice;
                            r_bus_addr  <= w_head.addr;
                            r_bus_data  <= w_head.payload[DATA_W-1:0];
                            r_ph_cnt    <= C_SETUP_LD;
                            r_state     <= ST_SETUP;
                        end else if (w_head.payload != '0) begin
                            r_wait_cnt <= w_head.payload;
                            r_state    <= ST_WAIT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_ph_cnt == C_PH_ONE) begin
                        r_ph_cnt <= C_STROBE_LD;
                        r_bus_we <= 1'b1;
                        r_state  <= ST_STROBE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt - C_PH_ONE;
                    end
                end
                ST_STROBE: begin
                    if (r_ph_cnt == C_PH_ONE) begin
                        r_ph_cnt <= C_HOLD_LD;
                        r_bus_we <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_ph_cnt <= r_ph_cnt - C_PH_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_ph_cnt == C_PH_ONE) begin
                        r_ph_cnt <= '0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt - C_PH_ONE;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - C_WAIT_ONE;
                    if (r_wait_cnt == C_WAIT_ONE) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_voice = r_bus_voice;
    assign bus_addr  = r_bus_addr;
    assign bus_data  = r_bus_data;
    assign bus_we    = r_bus_we;
    assign cmd_done  = r_done;
    assign overflow  = r_overflow;
    assign idle      = (r_state == ST_IDLE) && w_empty;

endmodule
`default_nettype wire
